// File: rtl/seven_segment_decode.sv
// rtl/seven_segment_decode.sv - debounced two-digit seven-segment pattern decoder with valid/ready output
// Optional SEVSEG_DP_CHECK_EN: a lit decimal point on either digit flags a decode error.
module seven_segment_decode #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [15:0] segIn,
   output logic [7:0]  outValue,
   output logic        outValid,
   input  logic        outReady,
   output logic        decodeErr,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SETTLE, DECODE, HOLD} state_t;

   // The increment that brings the counter to STABLE_CYCLES-1 is the edge that enters DECODE.
   localparam logic [7:0] LAST_STEP = 8'(STABLE_CYCLES - 2);

   state_t      state, state_next;
   logic [15:0] sampleReg, prevSample, lastPattern, last_next;
   logic [7:0]  counter, counter_next;
   logic [7:0]  value_next;
   logic        err_next;
   logic [4:0]  hi_lu, lo_lu;
   logic        hi_err, lo_err, dp_err;

   // Returns {miss, nibble}; a miss decodes as nibble 0.
   function automatic logic [4:0] lookup(input logic [6:0] pat);
      case (pat)
         7'h3F:   lookup = 5'h00;
         7'h06:   lookup = 5'h01;
         7'h5B:   lookup = 5'h02;
         7'h4F:   lookup = 5'h03;
         7'h66:   lookup = 5'h04;
         7'h6D:   lookup = 5'h05;
         7'h7D:   lookup = 5'h06;
         7'h07:   lookup = 5'h07;
         7'h7F:   lookup = 5'h08;
         7'h6F:   lookup = 5'h09;
         7'h77:   lookup = 5'h0A;
         7'h7C:   lookup = 5'h0B;
         7'h39:   lookup = 5'h0C;
         7'h5E:   lookup = 5'h0D;
         7'h79:   lookup = 5'h0E;
         7'h71:   lookup = 5'h0F;
         default: lookup = 5'h10;
      endcase
   endfunction

   always_comb begin
      hi_lu  = lookup(lastPattern[14:8]);
      lo_lu  = lookup(lastPattern[6:0]);
      // A blank high digit is a suppressed leading zero; a blank low digit is not.
      hi_err = hi_lu[4] & (lastPattern[14:8] != 7'h00);
      lo_err = lo_lu[4];
`ifdef SEVSEG_DP_CHECK_EN
      dp_err = lastPattern[15] | lastPattern[7];
`else
      dp_err = 1'b0;
`endif
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state       <= IDLE;
         sampleReg   <= '0;
         prevSample  <= '0;
         lastPattern <= '0;
         counter     <= '0;
         outValue    <= '0;
         decodeErr   <= 1'b0;
      end else begin
         state       <= state_next;
         sampleReg   <= segIn;
         prevSample  <= sampleReg;
         lastPattern <= last_next;
         counter     <= counter_next;
         outValue    <= value_next;
         decodeErr   <= err_next;
      end
   end

   always_comb begin
      state_next   = state;
      counter_next = counter;
      last_next    = lastPattern;
      value_next   = outValue;
      err_next     = decodeErr;
      case (state)
         IDLE: begin
            if (sampleReg != lastPattern) begin
               state_next   = SETTLE;
               counter_next = '0;
            end
         end
         SETTLE: begin
            if (sampleReg == prevSample) begin
               counter_next = counter + 8'd1;
               if (counter == LAST_STEP) begin
                  state_next = DECODE;
                  last_next  = sampleReg;
               end
            end else begin
               counter_next = '0;
            end
         end
         DECODE: begin
            value_next = {hi_lu[3:0], lo_lu[3:0]};
            err_next   = hi_err | lo_err | dp_err;
            state_next = HOLD;
         end
         HOLD: begin
            if (outReady) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign outValid = (state == HOLD);
   assign busy     = (state != IDLE);

endmodule
